tpu_matmul_sequencer: RTL and testbench

- Parametrised control sequencer for the systolic TPU datapath. It replaces the free-running counter and address-controller glue with a start/done-handshaked FSM.
- Per job it optionally pops one weight tile from the Weight FIFO and pulses the systolic weight reload. It then streams a programmable number of input rows from the Unified Buffer and writes each result row into the Results SRAM at a fixed pipeline latency.
- Sits between host control pins and the UB / Weight FIFO / systolic array / Results SRAM.

---
 rtl/tpu_matmul_sequencer_if.sv | 35 +++
 rtl/tpu_matmul_sequencer.sv | 149 ++++++++++++++
 tb/tb_tpu_matmul_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_matmul_sequencer_if.sv
// Handshake and bus bundle between host control, UB, Weight FIFO,
// systolic array and Results SRAM for tpu_matmul_sequencer.
// master: host/environment side, slave: the sequencer.
interface tpu_matmul_sequencer_if #(
   parameter int ADDRESSSIZE = 10
);
   logic                   start;
   logic                   reload_weights;
   logic [ADDRESSSIZE-1:0] src_base;
   logic [ADDRESSSIZE-1:0] dst_base;
   logic [ADDRESSSIZE-1:0] num_rows;
   logic                   fifo_empty;
   logic                   fifo_read_enable;
   logic                   we_rl;
   logic [ADDRESSSIZE-1:0] ub_address;
   logic                   ub_read_valid;
   logic                   res_write_enable;
   logic [ADDRESSSIZE-1:0] res_address;
   logic                   busy;
   logic                   done;
   logic                   error;
   logic [31:0]            cycle_count;

   modport master (
      output start, reload_weights, src_base, dst_base, num_rows, fifo_empty,
      input  fifo_read_enable, we_rl, ub_address, ub_read_valid,
             res_write_enable, res_address, busy, done, error, cycle_count
   );

   modport slave (
      input  start, reload_weights, src_base, dst_base, num_rows, fifo_empty,
      output fifo_read_enable, we_rl, ub_address, ub_read_valid,
             res_write_enable, res_address, busy, done, error, cycle_count
   );
endinterface

// File: rtl/tpu_matmul_sequencer.sv
// Start/done handshaked job sequencer for the systolic TPU datapath:
// optional weight tile pop + reload, row streaming from the UB, and
// result writes into the Results SRAM after a fixed pipeline latency.
// Optional build macro TPU_SEQ_PERF_EN enables the job cycle counter;
// without it cycle_count is tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; rejects reload requests on empty FIFO
// WFETCH | one-cycle Weight FIFO pop
// WLOAD  | one-cycle systolic weight reload pulse
// FEED   | one UB row address per cycle, num_rows cycles
// DRAIN  | waiting for the latency pipe to deliver its last write
// FIN    | one-cycle done pulse, busy already low
module tpu_matmul_sequencer #(
   parameter int MATRIX_SIZE = 8,
   parameter int ADDRESSSIZE = 10,
   parameter int LATENCY     = 2 * MATRIX_SIZE
) (
   input logic                   clk,
   input logic                   rstn,
   tpu_matmul_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WFETCH, S_WLOAD, S_FEED, S_DRAIN, S_FIN
   } state_t;

   // every stage except the output one; used to see whether more writes follow
   localparam logic [LATENCY-1:0] PIPE_MASK = {LATENCY{1'b1}} >> 1;

   state_t                 state, state_nxt;
   logic                   accept, reject, pending, last_row;
   logic [ADDRESSSIZE-1:0] rows_left;
   logic [ADDRESSSIZE-1:0] ub_addr_q, res_addr_q;
   logic [LATENCY-1:0]     pipe;
   logic                   error_q;
   logic                   fifo_rd_c, we_rl_c, ub_rv_c, busy_c, done_c;

   assign reject   = (state == S_IDLE) && bus.start && bus.reload_weights && bus.fifo_empty;
   assign accept   = (state == S_IDLE) && bus.start && !(bus.reload_weights && bus.fifo_empty);
   assign pending  = |(pipe & PIPE_MASK);
   assign last_row = (rows_left == ADDRESSSIZE'(1));

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state and state-decoded outputs
   always_comb begin
      state_nxt = state;
      fifo_rd_c = 1'b0;
      we_rl_c   = 1'b0;
      ub_rv_c   = 1'b0;
      busy_c    = 1'b0;
      done_c    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (bus.reload_weights)    state_nxt = S_WFETCH;
               // an empty job still spends one busy cycle before done
               else if (bus.num_rows == '0) state_nxt = S_DRAIN;
               else                       state_nxt = S_FEED;
            end
         end
         S_WFETCH: begin
            busy_c    = 1'b1;
            fifo_rd_c = 1'b1;
            state_nxt = S_WLOAD;
         end
         S_WLOAD: begin
            busy_c    = 1'b1;
            we_rl_c   = 1'b1;
            state_nxt = (rows_left == '0) ? S_FIN : S_FEED;
         end
         S_FEED: begin
            busy_c  = 1'b1;
            ub_rv_c = 1'b1;
            if (last_row) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy_c = 1'b1;
            // the output stage may hold the last write this cycle; nothing behind it
            if (!pending) state_nxt = S_FIN;
         end
         S_FIN: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // row down-counter, address generators, latency pipe and error pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rows_left  <= '0;
         ub_addr_q  <= '0;
         res_addr_q <= '0;
         pipe       <= '0;
         error_q    <= 1'b0;
      end else begin
         error_q <= reject;
         pipe    <= (pipe << 1) | LATENCY'(ub_rv_c);
         if (accept) begin
            rows_left <= bus.num_rows;
            ub_addr_q <= bus.src_base;
         end else if (state == S_FEED) begin
            rows_left <= rows_left - ADDRESSSIZE'(1);
            ub_addr_q <= ub_addr_q + ADDRESSSIZE'(1);
         end
         if (accept)                 res_addr_q <= bus.dst_base;
         else if (pipe[LATENCY-1])   res_addr_q <= res_addr_q + ADDRESSSIZE'(1);
      end
   end

   assign bus.fifo_read_enable = fifo_rd_c;
   assign bus.we_rl            = we_rl_c;
   assign bus.ub_read_valid    = ub_rv_c;
   assign bus.ub_address       = ub_addr_q;
   assign bus.res_write_enable = pipe[LATENCY-1];
   assign bus.res_address      = res_addr_q;
   assign bus.busy             = busy_c;
   assign bus.done             = done_c;
   assign bus.error            = error_q;

`ifdef TPU_SEQ_PERF_EN
   logic [31:0] perf_cnt, cycle_count_q;

   // job cycle counter, snapshot taken while done is shown
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_cnt      <= '0;
         cycle_count_q <= '0;
      end else begin
         if (accept)                perf_cnt <= '0;
         else if (state != S_IDLE)  perf_cnt <= perf_cnt + 32'd1;
         if (state == S_FIN)        cycle_count_q <= perf_cnt;
      end
   end

   assign bus.cycle_count = cycle_count_q;
`else
   assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Scoreboard bench for tpu_matmul_sequencer: each job pushes its expected
// events (cycle and address) and a negedge monitor pops them as they occur.
module tb_tpu_matmul_sequencer;

   localparam int AW  = 10;
   localparam int LAT = 16;

   typedef struct {
      int             cyc;
      logic [AW-1:0]  addr;
   } ev_t;

   logic clk = 1'b0;
   logic rstn = 1'b1;

   tpu_matmul_sequencer_if #(.ADDRESSSIZE(AW)) bus ();

   tpu_matmul_sequencer #(.MATRIX_SIZE(8), .ADDRESSSIZE(AW), .LATENCY(LAT)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int ncyc     = 0;
   int t0       = 0;
   int job_done_cyc = 0;
   int perf_at  = -1;
   int perf_exp = 0;

   ev_t exp_ub[$];
   ev_t exp_wr[$];
   int  exp_frd[$];
   int  exp_wrl[$];
   int  exp_done[$];
   int  exp_err[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) ncyc++;

   // monitor: pop and compare every observed event
   always @(negedge clk) begin
      int  rel;
      ev_t e;
      int  c;
      rel = ncyc - t0;
      if (rstn) begin
         chk("busy", {31'd0, bus.busy}, {31'd0, (rel >= 1) && (rel < job_done_cyc)});
         if (bus.ub_read_valid) begin
            if (exp_ub.size() != 0) e = exp_ub.pop_front();
            else begin e.cyc = -1; e.addr = '0; end
            chk("ub_cycle", rel, e.cyc);
            chk("ub_addr", {22'd0, bus.ub_address}, {22'd0, e.addr});
         end
         if (bus.res_write_enable) begin
            if (exp_wr.size() != 0) e = exp_wr.pop_front();
            else begin e.cyc = -1; e.addr = '0; end
            chk("wr_cycle", rel, e.cyc);
            chk("wr_addr", {22'd0, bus.res_address}, {22'd0, e.addr});
         end
         if (bus.fifo_read_enable) begin
            c = (exp_frd.size() != 0) ? exp_frd.pop_front() : -1;
            chk("fifo_rd_cycle", rel, c);
         end
         if (bus.we_rl) begin
            c = (exp_wrl.size() != 0) ? exp_wrl.pop_front() : -1;
            chk("we_rl_cycle", rel, c);
         end
         if (bus.error) begin
            c = (exp_err.size() != 0) ? exp_err.pop_front() : -1;
            chk("error_cycle", rel, c);
         end
         if (bus.done) begin
            c = (exp_done.size() != 0) ? exp_done.pop_front() : -1;
            chk("done_cycle", rel, c);
            perf_at = rel + 1;
`ifdef TPU_SEQ_PERF_EN
            perf_exp = c - 1;
`else
            perf_exp = 0;
`endif
         end
         if (rel == perf_at) begin
            chk("cycle_count", bus.cycle_count, perf_exp);
            perf_at = -1;
         end
      end
   end

   // drive one start request and push its expected events
   task automatic start_job(input bit rl, input bit fe, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst, input int n);
      int  off;
      int  d;
      ev_t e;
      @(posedge clk); #1;
      t0  = ncyc;
      off = rl ? 2 : 0;
      if (rl && fe) begin
         exp_err.push_back(1);
         job_done_cyc = 0;
      end else begin
         if (rl) begin
            exp_frd.push_back(1);
            exp_wrl.push_back(2);
         end
         for (int i = 0; i < n; i++) begin
            e.cyc = off + 1 + i;       e.addr = AW'(src + i); exp_ub.push_back(e);
            e.cyc = off + 1 + i + LAT; e.addr = AW'(dst + i); exp_wr.push_back(e);
         end
         d = (n == 0) ? (rl ? 3 : 2) : off + n + LAT + 1;
         exp_done.push_back(d);
         job_done_cyc = d;
      end
      bus.start          = 1'b1;
      bus.reload_weights = rl;
      bus.fifo_empty     = fe;
      bus.src_base       = src;
      bus.dst_base       = dst;
      bus.num_rows       = AW'(n);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.src_base = ~src;
      bus.dst_base = ~dst;
      bus.num_rows = AW'(n + 7);
   endtask

   // wait for the job to finish; optionally pulse start mid-job
   task automatic wait_job(input int pulse_at);
      int k = 0;
      while ((exp_done.size() + exp_err.size()) != 0 && k < 400) begin
         if ((ncyc - t0) == pulse_at) begin
            bus.start          = 1'b1;
            bus.reload_weights = 1'b0;
            bus.src_base       = 10'h155;
            bus.num_rows       = 10'd5;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         k++;
      end
      bus.start = 1'b0;
      chk("job_end", exp_done.size() + exp_err.size(), 0);
      repeat (4) @(posedge clk);
      #1;
      chk("ub_left", exp_ub.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      chk("frd_left", exp_frd.size(), 0);
      chk("wrl_left", exp_wrl.size(), 0);
   endtask

   task automatic run_job(input bit rl, input bit fe, input logic [AW-1:0] src,
                          input logic [AW-1:0] dst, input int n, input int pulse_at);
      start_job(rl, fe, src, dst, n);
      wait_job(pulse_at);
   endtask

   function automatic logic [31:0] outs_packed();
      return {5'd0, bus.busy, bus.done, bus.error, bus.fifo_read_enable, bus.we_rl,
              bus.ub_read_valid, bus.res_write_enable, bus.ub_address, bus.res_address};
   endfunction

   initial begin
      bus.start          = 1'b0;
      bus.reload_weights = 1'b0;
      bus.fifo_empty     = 1'b0;
      bus.src_base       = '0;
      bus.dst_base       = '0;
      bus.num_rows       = '0;
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", outs_packed(), 32'd0);
      chk("reset_cycle_count", bus.cycle_count, 32'd0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // basic stream, with a start pulse while busy
      run_job(1'b0, 1'b0, 10'h010, 10'h200, 4, 3);
      // weight reload first
      run_job(1'b1, 1'b0, 10'h040, 10'h100, 2, -1);
      // reload requested on empty FIFO: rejected
      run_job(1'b1, 1'b1, 10'h0AA, 10'h0BB, 3, -1);
      // address wrap on both sides
      run_job(1'b0, 1'b0, 10'h3FE, 10'h3FF, 3, -1);
      // empty job, start pulse during it
      run_job(1'b0, 1'b0, 10'h123, 10'h321, 0, 1);
      // empty job with reload
      run_job(1'b1, 1'b0, 10'h001, 10'h002, 0, -1);

      // reset in the middle of FEED (row 5 of 10)
      start_job(1'b0, 1'b0, 10'h020, 10'h300, 10);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("midjob_reset_outs", outs_packed(), 32'd0);
      chk("midjob_reset_cycle_count", bus.cycle_count, 32'd0);
      exp_ub.delete();
      exp_wr.delete();
      exp_done.delete();
      job_done_cyc = 0;
      perf_at = -1;
      repeat (3) @(posedge clk);
      #3 rstn = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("post_reset_idle", outs_packed() & 32'h07F0_0000, 32'd0);
      run_job(1'b0, 1'b0, 10'h050, 10'h060, 5, -1);

      // a few random jobs back to back
      for (int j = 0; j < 4; j++) begin
         run_job(1'($urandom_range(0, 1)), 1'b0, AW'($urandom_range(0, 1023)),
                 AW'($urandom_range(0, 1023)), $urandom_range(0, 6), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
